// File: rtl/fetch_pkg.sv
// Shared types for the IF stage: FSM states, buffered fetch entry, NOP encoding.
package fetch_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} pairs. Flush wins over same-cycle push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: PC owner, single-outstanding IM fetch FSM, redirect/kill handling, buffer to ID.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_taken_i,
    input  logic [31:0] redir_target_i,
    input  logic        redir_stall_i,
    output logic        im_req_valid_o,
    input  logic        im_req_ready_i,
    output logic [31:0] im_req_addr_o,
    input  logic        im_rsp_valid_i,
    input  logic [31:0] im_rsp_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        id_ready_i
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   pc;
    logic          kill;
    logic          redir;
    logic          push;
    logic          pop;
    logic          buf_full;
    logic [CW-1:0] buf_count;
    fetch_entry_t  head;

    assign redir    = redir_taken_i & ~redir_stall_i;
    assign buf_full = (buf_count == CW'(BUF_DEPTH));

    // Only request when a slot is guaranteed for the response.
    assign im_req_valid_o = rst_n & (state == REQ) & ~buf_full & ~redir;
    assign im_req_addr_o  = pc;

    assign push = (state == WAIT) & im_rsp_valid_i & ~kill & ~redir;
    assign pop  = if_valid_o & id_ready_i;

    assign if_valid_o = (buf_count != '0);
    assign if_pc_o    = if_valid_o ? head.pc   : '0;
    assign if_inst_o  = if_valid_o ? head.inst : NOP_INST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (redir)
                        pc <= redir_target_i;
                    else if (im_req_valid_o && im_req_ready_i)
                        state <= WAIT;
                end
                WAIT: begin
                    if (im_rsp_valid_i) begin
                        // A response always closes the outstanding request, live or killed.
                        state <= REQ;
                        kill  <= 1'b0;
                        if (redir)
                            pc <= redir_target_i;
                        else if (!kill)
                            pc <= pc + 32'd4;
                    end else if (redir) begin
                        pc   <= redir_target_i;
                        kill <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry ('{pc: pc, inst: im_rsp_data_i}),
        .pop        (pop),
        .flush      (redir),
        .head       (head),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a latency-programmable IM responder.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir_taken = 1'b0;
    logic [31:0] redir_target = '0;
    logic        redir_stall = 1'b0;
    logic        im_req_valid;
    logic        im_req_ready = 1'b1;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid = 1'b0;
    logic [31:0] im_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    logic [31:0] log_q [$];

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] OFS = 32'h1000_0000;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redir_taken_i  (redir_taken),
        .redir_target_i (redir_target),
        .redir_stall_i  (redir_stall),
        .im_req_valid_o (im_req_valid),
        .im_req_ready_i (im_req_ready),
        .im_req_addr_o  (im_req_addr),
        .im_rsp_valid_i (im_rsp_valid),
        .im_rsp_data_i  (im_rsp_data),
        .if_valid_o     (if_valid),
        .if_pc_o        (if_pc),
        .if_inst_o      (if_inst),
        .id_ready_i     (id_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        redir_taken  = 1'b0;
        redir_stall  = 1'b0;
        im_req_ready = 1'b1;
        lat          = 1;
        log_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_v", {31'b0, im_req_valid}, 32'd0);
        chk("rst_if_v",  {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_inst",  if_inst, NOP);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // IM model: data = addr + OFS, response lat cycles after the accepting edge.
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    always begin
        @(negedge clk);
        acc      = rst_n && im_req_valid && im_req_ready;
        acc_addr = im_req_addr;
        @(posedge clk);
        #1;
        im_rsp_valid = 1'b0;
        if (pend) begin
            if (cnt == 1) begin
                im_rsp_valid = 1'b1;
                im_rsp_data  = pend_addr + OFS;
                pend         = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (acc) begin
            if (lat == 1) begin
                im_rsp_valid = 1'b1;
                im_rsp_data  = acc_addr + OFS;
            end else begin
                pend      = 1'b1;
                cnt       = lat - 1;
                pend_addr = acc_addr;
            end
        end
    end

    // Consumption log: what ID actually takes, plus pc/inst pairing.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready && !(redir_taken && !redir_stall)) begin
            log_q.push_back(if_pc);
            chk("inst_pair", if_inst, if_pc + OFS);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=0", 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_a [5];
        logic [31:0] exp_b [5];
        exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_b = '{32'h0, 32'h100, 32'h200, 32'h400, 32'h404};

        // Phase A: in-order fetch, then ID stall filling the buffer.
        id_ready = 1'b1;
        do_reset();
        @(negedge clk); chk("a0_req_v", {31'b0, im_req_valid}, 1); chk("a0_addr", im_req_addr, 32'h0);
                        chk("a0_if_v", {31'b0, if_valid}, 0);
        go(1); @(negedge clk); chk("a1_req_v", {31'b0, im_req_valid}, 0);
        go(1); @(negedge clk); chk("a2_if_v", {31'b0, if_valid}, 1); chk("a2_pc", if_pc, 32'h0);
                               chk("a2_inst", if_inst, 32'h1000_0000); chk("a2_addr", im_req_addr, 32'h4);
        go(2); @(negedge clk); chk("a4_pc", if_pc, 32'h4);
        go(2); id_ready = 1'b0;
               @(negedge clk); chk("a6_pc", if_pc, 32'h8);
        go(2); @(negedge clk); chk("a8_full", {31'b0, im_req_valid}, 0); chk("a8_pc", if_pc, 32'h8);
        go(3); @(negedge clk); chk("a11_full", {31'b0, im_req_valid}, 0); chk("a11_pc", if_pc, 32'h8);
        go(1); id_ready = 1'b1;
               @(negedge clk); chk("a12_req_v", {31'b0, im_req_valid}, 0);
        go(1); @(negedge clk); chk("a13_req_v", {31'b0, im_req_valid}, 1); chk("a13_addr", im_req_addr, 32'h10);
                               chk("a13_pc", if_pc, 32'hC);
        go(2); @(negedge clk); chk("a15_pc", if_pc, 32'h10);
        #2;
        chk("a_log_n", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) chk("a_log", log_q[i], exp_a[i]);

        // Phase B: redirects (in WAIT, with rsp, stalled, in REQ), IM backpressure, reset mid-WAIT.
        id_ready = 1'b0;
        do_reset();
        @(negedge clk); chk("b0_addr", im_req_addr, 32'h0);
        go(4); id_ready = 1'b1; lat = 2;
               @(negedge clk); chk("b4_full", {31'b0, im_req_valid}, 0); chk("b4_pc", if_pc, 32'h0);
        go(1); id_ready = 1'b0;
               @(negedge clk); chk("b5_req_v", {31'b0, im_req_valid}, 1); chk("b5_addr", im_req_addr, 32'h8);
                               chk("b5_pc", if_pc, 32'h4);
        go(1); id_ready = 1'b1; redir_taken = 1'b1; redir_target = 32'h100;
               @(negedge clk); chk("b6_pc", if_pc, 32'h4); chk("b6_req_v", {31'b0, im_req_valid}, 0);
        go(1); redir_taken = 1'b0;
               @(negedge clk); chk("b7_flush", {31'b0, if_valid}, 0); chk("b7_nop", if_inst, NOP);
                               chk("b7_req_v", {31'b0, im_req_valid}, 0);
        go(1); @(negedge clk); chk("b8_req_v", {31'b0, im_req_valid}, 1); chk("b8_addr", im_req_addr, 32'h100);
                               chk("b8_if_v", {31'b0, if_valid}, 0);
        go(2); lat = 1;
        go(1); @(negedge clk); chk("b11_if_v", {31'b0, if_valid}, 1); chk("b11_pc", if_pc, 32'h100);
        go(1); redir_taken = 1'b1; redir_target = 32'h200;
               @(negedge clk); chk("b12_if_v", {31'b0, if_valid}, 0);
        go(1); redir_taken = 1'b0;
               @(negedge clk); chk("b13_addr", im_req_addr, 32'h200); chk("b13_req_v", {31'b0, im_req_valid}, 1);
                               chk("b13_if_v", {31'b0, if_valid}, 0);
        go(2); redir_taken = 1'b1; redir_stall = 1'b1; redir_target = 32'h300;
               @(negedge clk); chk("b15_pc", if_pc, 32'h200); chk("b15_req_v", {31'b0, im_req_valid}, 1);
                               chk("b15_addr", im_req_addr, 32'h204);
        go(1); redir_taken = 1'b0; redir_stall = 1'b0;
        go(1); redir_taken = 1'b1; redir_target = 32'h400;
               @(negedge clk); chk("b17_req_wd", {31'b0, im_req_valid}, 0); chk("b17_pc", if_pc, 32'h204);
        go(1); redir_taken = 1'b0;
               @(negedge clk); chk("b18_addr", im_req_addr, 32'h400); chk("b18_req_v", {31'b0, im_req_valid}, 1);
                               chk("b18_if_v", {31'b0, if_valid}, 0);
        go(2); im_req_ready = 1'b0;
               @(negedge clk); chk("b20_pc", if_pc, 32'h400);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) go(1);
            @(negedge clk);
            chk("bp_req_v", {31'b0, im_req_valid}, 1);
            chk("bp_addr", im_req_addr, 32'h404);
        end
        go(1); im_req_ready = 1'b1;
        go(2); lat = 3;
               @(negedge clk); chk("b25_pc", if_pc, 32'h404);
        go(2);
        chk("b_log_n", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) chk("b_log", log_q[i], exp_b[i]);
        rst_n = 1'b0; im_req_ready = 1'b0;
               @(negedge clk); chk("b27_req_v", {31'b0, im_req_valid}, 0); chk("b27_if_v", {31'b0, if_valid}, 0);
                               chk("b27_pc", if_pc, 32'h0); chk("b27_nop", if_inst, NOP);
        go(1); rst_n = 1'b1;
               @(negedge clk); chk("b28_req_v", {31'b0, im_req_valid}, 1); chk("b28_addr", im_req_addr, 32'h0);
                               chk("b28_if_v", {31'b0, if_valid}, 0);
        go(1); im_req_ready = 1'b1; lat = 1;
               @(negedge clk); chk("b29_stray", {31'b0, if_valid}, 0); chk("b29_addr", im_req_addr, 32'h0);
        go(2); @(negedge clk); chk("b31_if_v", {31'b0, if_valid}, 1); chk("b31_pc", if_pc, 32'h0);
                               chk("b31_inst", if_inst, 32'h1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
